// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction in, registered copy and
// upstream stall/enable controls out.
interface id_ex_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic [2:0]      id_funct3;
  logic            id_inst30;
  logic [1:0]      id_alu_op;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic            id_mem_to_reg, id_branch, id_alu_src;
  logic            flush, hold;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            ex_uses_rs1, ex_uses_rs2;
  logic [2:0]      ex_funct3;
  logic            ex_inst30;
  logic [1:0]      ex_alu_op;
  logic            ex_reg_write, ex_mem_read, ex_mem_write;
  logic            ex_mem_to_reg, ex_branch, ex_alu_src;
  logic            stall, pc_write, if_id_write;
  logic [CNT_W-1:0] bubble_count;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_funct3, id_inst30, id_alu_op, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src, flush, hold,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_uses_rs1, ex_uses_rs2, ex_funct3, ex_inst30, ex_alu_op, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src,
           stall, pc_write, if_id_write, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_funct3, id_inst30, id_alu_op, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg, id_branch, id_alu_src, flush, hold,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_uses_rs1, ex_uses_rs2, ex_funct3, ex_inst30, ex_alu_op, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src,
           stall, pc_write, if_id_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating bubble counter for performance debug.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic   clk,
  input logic   rst,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [2:0]      funct3;
    logic            inst30;
    logic [1:0]      alu_op;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
    logic            alu_src;
  } stage_t;

  stage_t           stage_q, stage_d, id_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_d, bump_d, rs_match_d;

  always_comb begin
    id_s = '{valid: bus.id_valid, pc: bus.id_pc, rs1_data: bus.id_rs1_data,
             rs2_data: bus.id_rs2_data, imm: bus.id_imm, rs1: bus.id_rs1,
             rs2: bus.id_rs2, rd: bus.id_rd, uses_rs1: bus.id_uses_rs1,
             uses_rs2: bus.id_uses_rs2, funct3: bus.id_funct3, inst30: bus.id_inst30,
             alu_op: bus.id_alu_op, reg_write: bus.id_reg_write,
             mem_read: bus.id_mem_read, mem_write: bus.id_mem_write,
             mem_to_reg: bus.id_mem_to_reg, branch: bus.id_branch,
             alu_src: bus.id_alu_src};

    // A bubble (all zeros) has valid=0 and rd=0, so it can never be a hazard source.
    rs_match_d = (bus.id_uses_rs1 && (stage_q.rd == bus.id_rs1)) ||
                 (bus.id_uses_rs2 && (stage_q.rd == bus.id_rs2));
    stall_d = bus.id_valid && !bus.flush && stage_q.valid && stage_q.mem_read &&
              (stage_q.rd != 5'd0) && rs_match_d;

    stage_d = stage_q;
    bump_d  = 1'b0;
    if (bus.flush) begin
      stage_d = '0;
      bump_d  = 1'b1;
    end else if (bus.hold) begin
      stage_d = stage_q;
    end else if (stall_d) begin
      stage_d = '0;
      bump_d  = 1'b1;
    end else begin
      stage_d = id_s;
    end

    cnt_d = (bump_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ex_valid      = stage_q.valid;
  assign bus.ex_pc         = stage_q.pc;
  assign bus.ex_rs1_data   = stage_q.rs1_data;
  assign bus.ex_rs2_data   = stage_q.rs2_data;
  assign bus.ex_imm        = stage_q.imm;
  assign bus.ex_rs1        = stage_q.rs1;
  assign bus.ex_rs2        = stage_q.rs2;
  assign bus.ex_rd         = stage_q.rd;
  assign bus.ex_uses_rs1   = stage_q.uses_rs1;
  assign bus.ex_uses_rs2   = stage_q.uses_rs2;
  assign bus.ex_funct3     = stage_q.funct3;
  assign bus.ex_inst30     = stage_q.inst30;
  assign bus.ex_alu_op     = stage_q.alu_op;
  assign bus.ex_reg_write  = stage_q.reg_write;
  assign bus.ex_mem_read   = stage_q.mem_read;
  assign bus.ex_mem_write  = stage_q.mem_write;
  assign bus.ex_mem_to_reg = stage_q.mem_to_reg;
  assign bus.ex_branch     = stage_q.branch;
  assign bus.ex_alu_src    = stage_q.alu_src;
  assign bus.stall         = stall_d;
  assign bus.pc_write      = !stall_d && !bus.hold;
  assign bus.if_id_write   = !stall_d && !bus.hold;
  assign bus.bubble_count  = cnt_q;
endmodule
